axi_rd_arbiter: RTL

- Shares one AXI4 read port (AR/R) between two requesters: port 0 is instruction fetch/ICache refill, port 1 is LSU/DCache refill.
- Sits between the cache/LSU read masters and the single AXI read channel toward the SoC crossbar.
- Serialises transactions; only one outstanding read at any time.
- Decides grant, latches the request and routes the R beats back to the winner until the last beat.

---
 rtl/axi_rd_arbiter_if.sv | 29 ++
 rtl/axi_rd_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-port bundle (AR + R channels) shared by the requester and
// downstream sides of axi_rd_arbiter.
//   master: drives the request and accepts data
//   slave : accepts the request and returns data
// Handshake: a transfer on a channel happens in the cycle where both valid and
// ready are high; the sender holds valid and payload stable until then.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic              r_valid;
   logic              r_ready;
   logic [DATA_W-1:0] r_data;
   logic              r_last;

   modport master (
      output ar_valid, ar_addr, ar_len, r_ready,
      input  ar_ready, r_valid, r_data, r_last
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len, r_ready,
      output ar_ready, r_valid, r_data, r_last
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter with one outstanding transaction.
// Port 0 = instruction fetch / ICache refill, port 1 = LSU / DCache refill.
// IDLE picks a winner and latches its AR payload, ADDR presents it downstream,
// DATA routes R beats to the winner until the last beat.
// Optional build macro AXI_RD_ARBITER_RR_EN: on simultaneous requests the port
// that did not own the previous completed transaction wins; otherwise port 1
// always beats port 0.
module axi_rd_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   axi_rd_arbiter_if.slave        s0,
   axi_rd_arbiter_if.slave        s1,
   axi_rd_arbiter_if.master       m,
   output logic [1:0]             grant,
   output logic [1:0]             dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic              pick1;     // port 1 wins the current IDLE arbitration
   logic              r_ready_sel; // r_ready of the granted requester
   logic              last_beat;  // final R beat handshakes this cycle

   assign r_ready_sel = grant_q[1] ? s1.r_ready : (grant_q[0] ? s0.r_ready : 1'b0);
   assign last_beat   = (state_q == DATA) && m.r_valid && r_ready_sel && m.r_last;

`ifdef AXI_RD_ARBITER_RR_EN
   logic last_owner_q, last_owner_d;

   // Winner select: alternate on contention, single requester wins at once
   always_comb begin
      if (s0.ar_valid && s1.ar_valid) pick1 = ~last_owner_q;
      else                            pick1 = s1.ar_valid;
   end

   // Remember who owned the transaction that just completed
   always_comb begin
      last_owner_d = last_owner_q;
      if (last_beat) last_owner_d = grant_q[1];
   end

   // Owner history register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) last_owner_q <= 1'b0;
      else       last_owner_q <= last_owner_d;
   end
`else
   assign pick1 = s1.ar_valid;
`endif

   // Next-state, grant and latched AR payload
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (s0.ar_valid || s1.ar_valid) begin
               state_d = ADDR;
               grant_d = pick1 ? 2'b10 : 2'b01;
               addr_d  = pick1 ? s1.ar_addr : s0.ar_addr;
               len_d   = pick1 ? s1.ar_len  : s0.ar_len;
            end
         end
         ADDR: begin
            if (m.ar_ready) state_d = DATA;
         end
         DATA: begin
            if (last_beat) begin
               state_d = IDLE;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // State and payload registers; reset abandons any transaction in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         addr_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
      end
   end

   // Handshake steering: AR ready to the owner in ADDR, R channel to the owner in DATA
   always_comb begin
      s0.ar_ready = 1'b0;
      s1.ar_ready = 1'b0;
      s0.r_valid  = 1'b0;
      s0.r_data   = {DATA_W{1'b0}};
      s0.r_last   = 1'b0;
      s1.r_valid  = 1'b0;
      s1.r_data   = {DATA_W{1'b0}};
      s1.r_last   = 1'b0;
      m.r_ready   = 1'b0;
      if (state_q == ADDR) begin
         s0.ar_ready = grant_q[0] & m.ar_ready;
         s1.ar_ready = grant_q[1] & m.ar_ready;
      end
      if (state_q == DATA) begin
         m.r_ready = r_ready_sel;
         if (grant_q[1]) begin
            s1.r_valid = m.r_valid;
            s1.r_data  = m.r_data;
            s1.r_last  = m.r_last;
         end else if (grant_q[0]) begin
            s0.r_valid = m.r_valid;
            s0.r_data  = m.r_data;
            s0.r_last  = m.r_last;
         end
      end
   end

   assign m.ar_valid  = (state_q == ADDR);
   assign m.ar_addr   = addr_q;
   assign m.ar_len    = len_q;
   assign grant       = grant_q;
   assign dbg_state_o = state_q;

endmodule
